// File: rtl/card_dealer_if.sv
// Request/card bus between the card source (card_dealer) and its consumer.
// The master drives the requests and the slave returns the dealt card and deck status.
interface card_dealer_if;
  logic       deal_req;
  logic       new_deck;
  logic [3:0] card_out;
  logic       card_valid;
  logic       busy;
  logic       deck_empty;
  logic [5:0] cards_left;

  modport master (
    output deal_req, new_deck,
    input  card_out, card_valid, busy, deck_empty, cards_left
  );

  modport slave (
    input  deal_req, new_deck,
    output card_out, card_valid, busy, deck_empty, cards_left
  );
endinterface

// File: rtl/card_dealer.sv
// Single 52-card deck dealer: samples a free-running 1..13 rank counter on request and
// skips exhausted ranks in ascending wrap-around order, so each rank is dealt at most four times.
module card_dealer (
  input  logic          CLOCK_50,
  input  logic          reset,
  card_dealer_if.slave  dif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] rank_cnt_q, rank_cnt_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] card_out_q, card_out_d;
  logic [5:0] cards_left_q, cards_left_d;
  logic [2:0] rem_q [13];
  logic [2:0] rem_d [13];
  logic [3:0] cand_idx;

  // rem[] is stored zero-based, so rank r lives in entry r-1
  assign cand_idx = cand_q - 4'd1;

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    card_out_d   = card_out_q;
    cards_left_d = cards_left_q;
    rem_d        = rem_q;
    rank_cnt_d   = (rank_cnt_q == 4'd13) ? 4'd1 : rank_cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (dif.new_deck) begin
          for (int i = 0; i < 13; i++) rem_d[i] = 3'd4;
          cards_left_d = 6'd52;
          card_out_d   = 4'd0;
        end else if (dif.deal_req && (cards_left_q != 6'd0)) begin
          cand_d  = rank_cnt_q;
          state_d = SEEK;
        end
      end
      SEEK: begin
        // A non-empty deck always hits within 13 steps of the wrap-around scan
        if (rem_q[cand_idx] != 3'd0) begin
          rem_d[cand_idx] = rem_q[cand_idx] - 3'd1;
          cards_left_d    = cards_left_q - 6'd1;
          card_out_d      = cand_q;
          state_d         = DELIVER;
        end else begin
          cand_d = (cand_q == 4'd13) ? 4'd1 : cand_q + 4'd1;
        end
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      rank_cnt_q   <= 4'd1;
      cand_q       <= 4'd1;
      card_out_q   <= 4'd0;
      cards_left_q <= 6'd52;
      for (int i = 0; i < 13; i++) rem_q[i] <= 3'd4;
    end else begin
      state_q      <= state_d;
      rank_cnt_q   <= rank_cnt_d;
      cand_q       <= cand_d;
      card_out_q   <= card_out_d;
      cards_left_q <= cards_left_d;
      for (int i = 0; i < 13; i++) rem_q[i] <= rem_d[i];
    end
  end

  assign dif.card_out   = card_out_q;
  assign dif.card_valid = (state_q == DELIVER);
  assign dif.busy       = (state_q != IDLE);
  assign dif.deck_empty = (cards_left_q == 6'd0);
  assign dif.cards_left = cards_left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset values, timed deals, rank skipping,
// full-deck exhaustion, new_deck on an empty deck and reset during SEEK.
module tb_card_dealer;

  logic CLOCK_50 = 1'b0;
  logic reset;
  int   vec_count = 0;
  int   miscompares = 0;
  int   model_rank = 1;
  int   tally [16];

  card_dealer_if dif ();

  card_dealer dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .dif      (dif)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Expected rank counter value: the rank a request would sample at the next edge
  always @(posedge CLOCK_50) begin
    if (reset) model_rank <= 1;
    else       model_rank <= (model_rank == 13) ? 1 : model_rank + 1;
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Waits until the sampled rank is 'rank', issues one request and measures the latency
  task automatic applyStimulus(input string tag, input int rank, input int exp_card,
                               input int exp_edges);
    int guard;
    int edges;
    guard = 0;
    while (model_rank != rank && guard < 30) begin
      step();
      guard++;
    end
    checkOutput({tag, "_align"}, model_rank, rank);
    dif.deal_req = 1'b1;
    step();
    dif.deal_req = 1'b0;
    edges = 1;
    while (!dif.card_valid && edges < 20) begin
      step();
      edges++;
    end
    checkOutput({tag, "_latency"}, edges, exp_edges);
    checkOutput({tag, "_card"}, int'(dif.card_out), exp_card);
    step();
  endtask

  initial begin
    int deals;
    int cycles;
    int saw_valid;
    int saw_busy;

    reset        = 1'b1;
    dif.deal_req = 1'b0;
    dif.new_deck = 1'b0;
    for (int i = 0; i < 16; i++) tally[i] = 0;
    repeat (3) step();
    reset = 1'b0;

    checkOutput("rst_card_out", int'(dif.card_out), 0);
    checkOutput("rst_card_valid", int'(dif.card_valid), 0);
    checkOutput("rst_busy", int'(dif.busy), 0);
    checkOutput("rst_cards_left", int'(dif.cards_left), 52);
    checkOutput("rst_deck_empty", int'(dif.deck_empty), 0);

    // First deal right after reset release samples rank 1
    dif.deal_req = 1'b1;
    step();
    dif.deal_req = 1'b0;
    checkOutput("first_busy", int'(dif.busy), 1);
    checkOutput("first_valid_early", int'(dif.card_valid), 0);
    step();
    checkOutput("first_card", int'(dif.card_out), 1);
    checkOutput("first_valid", int'(dif.card_valid), 1);
    checkOutput("first_cards_left", int'(dif.cards_left), 51);
    step();
    checkOutput("first_valid_drop", int'(dif.card_valid), 0);
    checkOutput("first_busy_drop", int'(dif.busy), 0);

    // Four kings, then a fifth request at 13 wraps to an ace after one skip
    applyStimulus("king1", 13, 13, 2);
    applyStimulus("king2", 13, 13, 2);
    applyStimulus("king3", 13, 13, 2);
    applyStimulus("king4", 13, 13, 2);
    applyStimulus("king_skip", 13, 1, 3);
    checkOutput("after_kings_left", int'(dif.cards_left), 46);

    // Hold deal_req high for the remaining 46 cards
    tally[1]  = 2;
    tally[13] = 4;
    deals  = 0;
    cycles = 0;
    dif.deal_req = 1'b1;
    while (deals < 46 && cycles < 2000) begin
      step();
      cycles++;
      if (dif.card_valid) begin
        tally[dif.card_out]++;
        deals++;
      end
    end
    checkOutput("bulk_deals", deals, 46);
    for (int r = 1; r <= 13; r++) checkOutput($sformatf("tally_rank%0d", r), tally[r], 4);
    checkOutput("tally_rank0", tally[0], 0);
    step();
    checkOutput("empty_flag", int'(dif.deck_empty), 1);
    checkOutput("empty_left", int'(dif.cards_left), 0);
    saw_valid = 0;
    saw_busy  = 0;
    repeat (10) begin
      step();
      if (dif.card_valid) saw_valid++;
      if (dif.busy) saw_busy++;
    end
    checkOutput("empty_no_valid", saw_valid, 0);
    checkOutput("empty_no_busy", saw_busy, 0);

    // new_deck wins over a simultaneous deal_req on an empty deck
    dif.new_deck = 1'b1;
    step();
    dif.new_deck = 1'b0;
    dif.deal_req = 1'b0;
    checkOutput("reload_left", int'(dif.cards_left), 52);
    checkOutput("reload_card", int'(dif.card_out), 0);
    checkOutput("reload_empty", int'(dif.deck_empty), 0);
    checkOutput("reload_busy", int'(dif.busy), 0);
    checkOutput("reload_valid", int'(dif.card_valid), 0);
    step();
    checkOutput("reload_valid_next", int'(dif.card_valid), 0);
    checkOutput("reload_busy_next", int'(dif.busy), 0);

    // Reset while in SEEK aborts the deal
    applyStimulus("pre_abort", 5, 5, 2);
    checkOutput("pre_abort_left", int'(dif.cards_left), 51);
    dif.deal_req = 1'b1;
    step();
    dif.deal_req = 1'b0;
    checkOutput("abort_seek_busy", int'(dif.busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("abort_valid", int'(dif.card_valid), 0);
    checkOutput("abort_busy", int'(dif.busy), 0);
    checkOutput("abort_card", int'(dif.card_out), 0);
    checkOutput("abort_left", int'(dif.cards_left), 52);
    step();
    checkOutput("abort_valid_next", int'(dif.card_valid), 0);
    checkOutput("abort_left_next", int'(dif.cards_left), 52);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
